// File: rtl/dino_pkg.sv
// Shared obstacle constants and spawner state encoding for the dino game blocks.
package dino_pkg;

    localparam logic [1:0] OBS_SMALL = 2'd0;
    localparam logic [1:0] OBS_LARGE = 2'd1;
    localparam logic [1:0] OBS_GROUP = 2'd2;
    localparam logic [1:0] OBS_BIRD  = 2'd3;

    localparam logic [1:0] H_LOW  = 2'd0;
    localparam logic [1:0] H_MID  = 2'd1;
    localparam logic [1:0] H_HIGH = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        OFFER = 2'd2
    } spawn_state_t;

endpackage

// File: rtl/spawn_decode.sv
// Maps random bits and difficulty level to obstacle type and bird height.
module spawn_decode
    import dino_pkg::*;
#(
    parameter int BIRD_LEVEL = 2
) (
    input  logic [1:0] rnd_type,
    input  logic [1:0] rnd_height,
    input  logic [1:0] level,
    output logic [1:0] obs_type,
    output logic [1:0] obs_height
);

    localparam logic [2:0] BIRD_LVL = 3'(BIRD_LEVEL);

    always_comb begin
        obs_type   = rnd_type;
        obs_height = H_LOW;
        // Below the bird level a would-be bird falls back to a small cactus.
        if (rnd_type == OBS_BIRD && {1'b0, level} < BIRD_LVL)
            obs_type = OBS_SMALL;
        if (obs_type == OBS_BIRD) begin
            case (rnd_height)
                2'b00:   obs_height = H_LOW;
                2'b01:   obs_height = H_MID;
                2'b10:   obs_height = H_HIGH;
                default: obs_height = H_MID;
            endcase
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Counts frame ticks through a randomised gap, then offers one obstacle spawn
// request over a valid/ack handshake.
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int MIN_GAP    = 40,
    parameter int GAP_W      = 8,
    parameter int BIRD_LEVEL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rnd,
    input  logic       tick,
    input  logic       game_run,
    input  logic [1:0] level,
    input  logic       spawn_ack,
    output logic       spawn_valid,
    output logic [1:0] spawn_type,
    output logic [1:0] spawn_height,
    output logic [7:0] spawn_count
);

    spawn_state_t     state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       type_q, type_d;
    logic [1:0]       height_q, height_d;
    logic [7:0]       count_q, count_d;

    logic [1:0]       dec_type, dec_height;
    logic [GAP_W-1:0] gap_load;

    spawn_decode #(.BIRD_LEVEL(BIRD_LEVEL)) u_decode (
        .rnd_type  (rnd[7:6]),
        .rnd_height(rnd[1:0]),
        .level     (level),
        .obs_type  (dec_type),
        .obs_height(dec_height)
    );

    // Higher levels shift the random part down, shortening the average gap.
    assign gap_load = GAP_W'(MIN_GAP) + GAP_W'(rnd[5:0] >> level);

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        valid_d   = valid_q;
        type_d    = type_q;
        height_d  = height_q;
        count_d   = count_q;
        if (!game_run) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    gap_cnt_d = gap_load;
                    state_d   = GAP;
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt_q == GAP_W'(1)) begin
                            state_d   = OFFER;
                            valid_d   = 1'b1;
                            type_d    = dec_type;
                            height_d  = dec_height;
                            gap_cnt_d = '0;
                        end else begin
                            gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        end
                    end
                end
                OFFER: begin
                    if (spawn_ack) begin
                        valid_d   = 1'b0;
                        count_d   = count_q + 8'd1;
                        gap_cnt_d = gap_load;
                        state_d   = GAP;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    gap_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            type_q    <= OBS_SMALL;
            height_q  <= H_LOW;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            type_q    <= type_d;
            height_q  <= height_d;
            count_q   <= count_d;
        end
    end

    assign spawn_valid  = valid_q;
    assign spawn_type   = type_q;
    assign spawn_height = height_q;
    assign spawn_count  = count_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomised and directed bench for obstacle_spawner against a tick-counting model.
module tb_obstacle_spawner;

    localparam int MIN_GAP = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rnd;
    logic       tick;
    logic       game_run;
    logic [1:0] level;
    logic       spawn_ack;
    logic       spawn_valid;
    logic [1:0] spawn_type;
    logic [1:0] spawn_height;
    logic [7:0] spawn_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    obstacle_spawner #(.MIN_GAP(MIN_GAP), .GAP_W(8), .BIRD_LEVEL(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .rnd         (rnd),
        .tick        (tick),
        .game_run    (game_run),
        .level       (level),
        .spawn_ack   (spawn_ack),
        .spawn_valid (spawn_valid),
        .spawn_type  (spawn_type),
        .spawn_height(spawn_height),
        .spawn_count (spawn_count)
    );

    function automatic int exp_gap(int r, int l);
        return MIN_GAP + (r % 64) / (1 << l);
    endfunction

    function automatic int exp_type(int r, int l);
        int t = r / 64;
        if (t == 3 && l < 2) return 0;
        return t;
    endfunction

    function automatic int exp_h(int r, int l);
        if (exp_type(r, l) != 3) return 0;
        case (r % 4)
            0: return 0;
            1: return 1;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    // Model: ticks still to wait (0 when idle or offering), pending offer, payload, count.
    int   m_left;
    logic m_pend;
    int   m_cnt, m_type, m_h;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0; m_pend <= 1'b0; m_cnt <= 0; m_type <= 0; m_h <= 0;
        end else if (!game_run) begin
            m_left <= 0; m_pend <= 1'b0;
        end else if (!m_pend && m_left == 0) begin
            m_left <= exp_gap(rnd, level);
        end else if (!m_pend) begin
            if (tick) begin
                if (m_left == 1) begin
                    m_pend <= 1'b1; m_left <= 0;
                    m_type <= exp_type(rnd, level); m_h <= exp_h(rnd, level);
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end else if (spawn_ack) begin
            m_pend <= 1'b0;
            m_cnt  <= (m_cnt + 1) % 256;
            m_left <= exp_gap(rnd, level);
        end
    end

    task automatic do_reset();
        rst = 1'b0; game_run = 1'b0; tick = 1'b0; spawn_ack = 1'b0; level = 2'd0; rnd = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Tick every clock until the model reports an offer; the final tick sees latch_rnd/latch_lvl.
    task automatic run_to_offer(input logic [7:0] latch_rnd, input logic [1:0] latch_lvl);
        int n = 0;
        while (!m_pend && n < 600) begin
            spawn_ack = 1'b0; tick = 1'b1;
            if (m_left == 1) begin rnd = latch_rnd; level = latch_lvl; end
            else rnd = 8'($urandom);
            @(negedge clk);
            n++;
        end
        tick = 1'b0;
        checks++;
        if (!m_pend) begin
            failures++; $display("FAIL offer_timeout: got no offer after %0d clks required <600", n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({spawn_valid, spawn_type, spawn_height, spawn_count} !== 13'd0) begin
            failures++; $display("FAIL reset_values: got %h required 0", {spawn_valid, spawn_type, spawn_height, spawn_count});
        end
        game_run = 1'b1;
        run_to_offer(8'h40, 2'd0);
        spawn_ack = 1'b1; @(negedge clk); spawn_ack = 1'b0;
        run_to_offer(8'h80, 2'd0);
        checks++;
        if ({spawn_valid, spawn_type, spawn_count} !== {1'b1, 2'd2, 8'd1}) begin
            failures++; $display("FAIL pre_reset_offer: got %h required %h", {spawn_valid, spawn_type, spawn_count}, {1'b1, 2'd2, 8'd1});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({spawn_valid, spawn_type, spawn_height, spawn_count} !== 13'd0) begin
            failures++; $display("FAIL async_reset: got %h required 0", {spawn_valid, spawn_type, spawn_height, spawn_count});
        end
        @(negedge clk);
        game_run = 1'b0; rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick = 1'(i % 2); rnd = 8'($urandom);
            @(negedge clk);
            checks++;
            if (spawn_valid !== 1'b0) begin
                failures++; $display("FAIL idle_after_reset: got valid=%b required 0 at clk %0d", spawn_valid, i);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_gap_timing();
        int nt = 0;
        int c  = 0;
        logic [7:0] lr = 8'd0;
        do_reset();
        level = 2'd0; rnd = 8'h05; game_run = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            tick = 1'b0; rnd = 8'($urandom);
            @(negedge clk);
            checks++;
            if (spawn_valid !== 1'b0) begin
                failures++; $display("FAIL no_tick_no_spawn: got valid=%b required 0 at clk %0d", spawn_valid, i);
            end
        end
        while (nt < 45 && c < 400) begin
            tick = (c % 4 == 0); rnd = 8'($urandom);
            if (tick) lr = rnd;
            @(negedge clk);
            if (tick) begin
                nt++;
                checks++;
                if (spawn_valid !== (nt >= 45)) begin
                    failures++; $display("FAIL gap45_timing: got valid=%b required %b at tick %0d", spawn_valid, (nt >= 45), nt);
                end
            end
            c++;
        end
        tick = 1'b0;
        checks++;
        if ({spawn_type, spawn_height} !== {2'(exp_type(lr, 0)), 2'(exp_h(lr, 0))}) begin
            failures++; $display("FAIL gap45_payload: got %h required %h", {spawn_type, spawn_height}, {2'(exp_type(lr, 0)), 2'(exp_h(lr, 0))});
        end
    endtask

    task automatic test_bird_gating();
        logic [7:0] rs [3] = '{8'hC2, 8'hC2, 8'hC3};
        logic [1:0] ls [3] = '{2'd0, 2'd2, 2'd3};
        logic [1:0] ets[3] = '{2'd0, 2'd3, 2'd3};
        logic [1:0] ehs[3] = '{2'd0, 2'd2, 2'd1};
        do_reset();
        game_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_to_offer(rs[k], ls[k]);
            checks++;
            if ({spawn_type, spawn_height} !== {ets[k], ehs[k]}) begin
                failures++; $display("FAIL bird_gate_%0d: got type=%0d h=%0d required type=%0d h=%0d", k, spawn_type, spawn_height, ets[k], ehs[k]);
            end
            spawn_ack = 1'b1; @(negedge clk); spawn_ack = 1'b0;
        end
    endtask

    task automatic test_handshake();
        logic [1:0] t0, h0;
        int nt = 0;
        do_reset();
        game_run = 1'b1;
        run_to_offer(8'($urandom), 2'($urandom));
        t0 = 2'(m_type); h0 = 2'(m_h);
        for (int i = 0; i < 10; i++) begin
            spawn_ack = 1'b0; tick = 1'($urandom); rnd = 8'($urandom); level = 2'($urandom);
            @(negedge clk);
            checks++;
            if ({spawn_valid, spawn_type, spawn_height} !== {1'b1, t0, h0}) begin
                failures++; $display("FAIL hold_offer: got %b required %b at clk %0d", {spawn_valid, spawn_type, spawn_height}, {1'b1, t0, h0}, i);
            end
        end
        spawn_ack = 1'b1; rnd = 8'h0A; level = 2'd0; tick = 1'b1;
        @(negedge clk);
        spawn_ack = 1'b0;
        checks++;
        if ({spawn_valid, spawn_count} !== {1'b0, 8'd1}) begin
            failures++; $display("FAIL ack_accept: got valid=%b count=%0d required valid=0 count=1", spawn_valid, spawn_count);
        end
        for (int c = 0; c < 300 && !spawn_valid; c++) begin
            tick = 1'($urandom); rnd = 8'($urandom); level = 2'($urandom);
            @(negedge clk);
            if (tick) nt++;
        end
        tick = 1'b0;
        checks++;
        if (spawn_valid !== 1'b1 || nt != 50) begin
            failures++; $display("FAIL regap50: got valid=%b ticks=%0d required valid=1 ticks=50", spawn_valid, nt);
        end
    endtask

    task automatic test_wrap();
        int nt = 0;
        do_reset();
        game_run = 1'b1; level = 2'd3; rnd = 8'h3F;
        @(negedge clk);
        for (int c = 0; c < 200 && !spawn_valid; c++) begin
            tick = 1'b1; rnd = 8'($urandom); level = 2'($urandom);
            @(negedge clk);
            nt++;
        end
        tick = 1'b0;
        checks++;
        if (spawn_valid !== 1'b1 || nt != 47) begin
            failures++; $display("FAIL gap47_level3: got valid=%b ticks=%0d required valid=1 ticks=47", spawn_valid, nt);
        end
        for (int i = 0; i < 256; i++) begin
            run_to_offer(8'($urandom), 2'($urandom));
            checks++;
            if ({spawn_valid, spawn_type, spawn_height} !== {1'b1, 2'(m_type), 2'(m_h)}) begin
                failures++; $display("FAIL wrap_payload_%0d: got %b required %b", i, {spawn_valid, spawn_type, spawn_height}, {1'b1, 2'(m_type), 2'(m_h)});
            end
            repeat ($urandom_range(0, 2)) begin
                tick = 1'($urandom); rnd = 8'($urandom); @(negedge clk);
            end
            tick = 1'b0; spawn_ack = 1'b1; rnd = 8'($urandom);
            @(negedge clk);
            spawn_ack = 1'b0;
            checks++;
            if (spawn_count !== 8'((i + 1) % 256)) begin
                failures++; $display("FAIL wrap_count_%0d: got %0d required %0d", i, spawn_count, (i + 1) % 256);
            end
        end
        checks++;
        if (spawn_count !== 8'd0) begin
            failures++; $display("FAIL count_wrap_zero: got %0d required 0", spawn_count);
        end
    endtask

    task automatic test_abort();
        int nt = 0;
        do_reset();
        game_run = 1'b1;
        run_to_offer(8'($urandom), 2'd1);
        spawn_ack = 1'b1; @(negedge clk); spawn_ack = 1'b0;
        run_to_offer(8'($urandom), 2'd1);
        game_run = 1'b0; spawn_ack = 1'b1;
        @(negedge clk);
        spawn_ack = 1'b0;
        checks++;
        if ({spawn_valid, spawn_count} !== {1'b0, 8'd1}) begin
            failures++; $display("FAIL abort_drop: got valid=%b count=%0d required valid=0 count=1", spawn_valid, spawn_count);
        end
        for (int i = 0; i < 20; i++) begin
            tick = 1'b1; rnd = 8'($urandom);
            @(negedge clk);
        end
        checks++;
        if (spawn_valid !== 1'b0) begin
            failures++; $display("FAIL abort_idle: got valid=%b required 0", spawn_valid);
        end
        game_run = 1'b1; rnd = 8'h17; level = 2'd1; tick = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 200 && !spawn_valid; c++) begin
            tick = 1'b1; rnd = 8'($urandom);
            @(negedge clk);
            nt++;
        end
        tick = 1'b0;
        checks++;
        if (spawn_valid !== 1'b1 || nt != 51) begin
            failures++; $display("FAIL abort_regap: got valid=%b ticks=%0d required valid=1 ticks=51", spawn_valid, nt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            game_run  = ($urandom % 64) != 0;
            tick      = ($urandom % 3) == 0;
            spawn_ack = ($urandom % 4) == 0;
            rnd       = 8'($urandom);
            if ($urandom % 16 == 0) level = 2'($urandom);
            @(negedge clk);
            checks++;
            if (spawn_valid !== m_pend || spawn_count !== 8'(m_cnt) ||
                (m_pend && {spawn_type, spawn_height} !== {2'(m_type), 2'(m_h)})) begin
                failures++;
                $display("FAIL random_%0d: got v=%b c=%0d t=%0d h=%0d required v=%b c=%0d t=%0d h=%0d",
                         i, spawn_valid, spawn_count, spawn_type, spawn_height, m_pend, m_cnt, m_type, m_h);
            end
        end
        spawn_ack = 1'b0; tick = 1'b0;
    endtask

    initial begin
        rst = 1'b0; game_run = 1'b0; tick = 1'b0; spawn_ack = 1'b0; level = 2'd0; rnd = 8'd0;
        @(negedge clk);
        test_reset();
        test_gap_timing();
        test_bird_gating();
        test_handshake();
        test_wrap();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Consumes the 8-bit pseudo-random byte from the LFSR stage and decides when and what the next obstacle in the dino game is.
- Counts frame ticks through a randomised gap, then offers one spawn request (type, height) over a valid/ack handshake to the downstream obstacle renderer.
- Difficulty level shortens gaps and enables birds.

Parameters:
- MIN_GAP, 40, minimum ticks between spawns; legal range 1..192.
- GAP_W, 8, width of the gap counter; must satisfy MIN_GAP+63 < 2^GAP_W.
- BIRD_LEVEL, 2, lowest level at which bird obstacles are allowed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rnd  in  8  random byte from the LFSR; changes every clk.
- tick  in  1  one-clk frame pulse.
- game_run  in  1  high while a game is in progress.
- level  in  2  difficulty level, 0..3.
- spawn_ack  in  1  downstream accepts the request.
- spawn_valid  out  1  spawn request pending.
- spawn_type  out  2  0 small cactus, 1 large cactus, 2 cactus group, 3 bird.
- spawn_height  out  2  bird height: 0 low, 1 mid, 2 high; 0 for cacti.
- spawn_count  out  8  number of accepted spawns, wraps at 255 to 0.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, gap_cnt=0, spawn_valid=0, spawn_type=0, spawn_height=0, spawn_count=0. All outputs are registered.
- States: IDLE, GAP, OFFER.
- IDLE:
  - If game_run=1 at the clk edge: load gap_cnt = MIN_GAP + (rnd[5:0] >> level), then go to GAP.
  - Otherwise stay in IDLE.
- GAP:
  - gap_cnt decrements only on clk edges where tick=1.
  - When tick=1 and gap_cnt==1: go to OFFER on that edge, set spawn_valid=1, and latch type and height from rnd at that edge.
  - Net latency: spawn_valid rises on the edge of the gap_cnt-th tick after arming.
- Type decode from rnd[7:6]:
  - 0, 1 and 2 map directly to the same type.
  - 3 gives bird only if level >= BIRD_LEVEL; otherwise type 0.
- Height decode (birds only), from rnd[1:0]: 00 gives 0, 01 gives 1, 10 gives 2, 11 gives 1. Cacti always get height 0.
- OFFER:
  - spawn_valid stays 1 with type and height held stable until spawn_ack=1 at a clk edge.
  - On that edge: spawn_valid=0, spawn_count+1 (mod 256), gap_cnt reloaded with the same formula using the current rnd and level, next state GAP.
  - tick is ignored in OFFER; no tick backlog accumulates.
- spawn_ack while spawn_valid=0 has no effect.
- game_run=0 in any state: at the next edge go to IDLE, set spawn_valid=0 and gap_cnt=0. A pending offer is dropped and spawn_count is unchanged. game_run=0 has priority over a simultaneous spawn_ack.
- level is sampled only at gap load and type latch. A level change mid-gap does not alter the running count.
- rst asserted in mid-operation forces the reset values immediately, with no handshake completion.

Decomposition:
- Shared package dino_pkg holds:
  - the obstacle type constants: OBS_SMALL=0, OBS_LARGE=1, OBS_GROUP=2, OBS_BIRD=3;
  - the height constants: H_LOW, H_MID, H_HIGH;
  - the state enum: IDLE, GAP, OFFER.
- One natural sub-module, spawn_decode: combinational mapping of rnd and level to type and height, reusable by the renderer's tests.
- Gap counter and FSM stay in the top module.

Test Plan:
- Reset: rst=0 mid-OFFER with spawn_valid=1 → spawn_valid, spawn_type, spawn_height and spawn_count all read 0 immediately; after rst=1 the block stays in IDLE while game_run=0.
- Gap timing, level 0: arm with rnd=8'h05 → gap 45. Pulse tick every 4 clks → spawn_valid rises exactly on the 45th tick edge. Ticks held low for 100 clks → no spawn.
- Bird gating:
  - rnd=8'hC2 at latch with level=0 → type 0, height 0.
  - Same rnd with level=2 → type 3, height 2.
  - rnd=8'hC3 with level=3 → type 3, height 1.
- Handshake: hold spawn_ack=0 for 10 clks → spawn_valid=1 and payload unchanged throughout. Then ack for 1 clk → valid=0 on the next edge, spawn_count goes 0 to 1, new gap loaded. Ticks during OFFER do not shorten the new gap.
- Gap scaling and wrap: level=3, rnd[5:0]=63 → gap 47. Run 256 accepted spawns → spawn_count reads 0.
- Abort: drop game_run with spawn_ack=1 in the same clk during OFFER → next edge spawn_valid=0, spawn_count unchanged, state IDLE. Re-raise game_run → a fresh gap is loaded.
